// File: rtl/mux_8_1_scanner.sv
// Purpose: steps an 8:1 MUX through the enabled channels and packs the sampled bits into one snapshot.
// Latency: each channel is held DWELL_CYCLES cycles; snapshot is valid after N*DWELL_CYCLES edges from Start.
// Backpressure: Frame_Valid_Out holds until Frame_Ready_In; a new scan end while unaccepted overwrites and sets Overrun_Out.
module mux_8_1_scanner #(
   parameter int unsigned DWELL_CYCLES = 4
) (
   input  logic       Clock_In,
   input  logic       Reset_In,
   input  logic       Start_In,
   input  logic [7:0] Channel_Mask_In,
   input  logic       Continuous_In,
   input  logic       MUX_Data_In,
   output logic [2:0] Select_Out,
   output logic       Enable_Out,
   output logic [7:0] Frame_Data_Out,
   output logic       Frame_Valid_Out,
   input  logic       Frame_Ready_In,
   output logic       Busy_Out,
   output logic       Overrun_Out
);

   typedef enum logic {
      IDLE  = 1'b0,
      DWELL = 1'b1
   } state_t;

   // Counter value reached on the last edge of a dwell; that edge samples the MUX.
   localparam logic [7:0] CNT_LAST = 8'(DWELL_CYCLES - 1);

   state_t     state_q, state_nxt;
   logic [2:0] sel_q, sel_nxt;
   logic       en_q, en_nxt;
   logic       busy_q, busy_nxt;
   logic [7:0] mask_q, mask_nxt;
   logic [7:0] shadow_q, shadow_nxt;
   logic [7:0] cnt_q, cnt_nxt;
   logic [7:0] frame_q, frame_nxt;
   logic       vld_q, vld_nxt;
   logic       ovr_q, ovr_nxt;

   logic [7:0] sample_shadow;
   logic [7:0] remaining;

   // Index of the lowest set bit; callers only use it with a non-zero mask.
   function automatic logic [2:0] lowest_bit(input logic [7:0] m);
      lowest_bit = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lowest_bit = 3'(i);
      end
   endfunction

   // Bits strictly above position s.
   function automatic logic [7:0] above_mask(input logic [2:0] s);
      above_mask = 8'd0;
      for (int i = 0; i < 8; i++) begin
         above_mask[i] = (i > int'(s));
      end
   endfunction

   // Register all scanner state; reset clears everything immediately.
   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q  <= IDLE;
         sel_q    <= 3'd0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         mask_q   <= 8'd0;
         shadow_q <= 8'd0;
         cnt_q    <= 8'd0;
         frame_q  <= 8'd0;
         vld_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         sel_q    <= sel_nxt;
         en_q     <= en_nxt;
         busy_q   <= busy_nxt;
         mask_q   <= mask_nxt;
         shadow_q <= shadow_nxt;
         cnt_q    <= cnt_nxt;
         frame_q  <= frame_nxt;
         vld_q    <= vld_nxt;
         ovr_q    <= ovr_nxt;
      end
   end

   // Next-state: scan sequencing, sampling, snapshot handoff and overrun tracking.
   always_comb begin
      state_nxt  = state_q;
      sel_nxt    = sel_q;
      en_nxt     = en_q;
      busy_nxt   = busy_q;
      mask_nxt   = mask_q;
      shadow_nxt = shadow_q;
      cnt_nxt    = cnt_q;
      frame_nxt  = frame_q;
      vld_nxt    = vld_q;
      ovr_nxt    = ovr_q;

      // Shadow as it would look with the current MUX bit merged in.
      sample_shadow        = shadow_q;
      sample_shadow[sel_q] = MUX_Data_In;
      remaining            = mask_q & above_mask(sel_q);

      // Consumer accepts; a scan end on this same edge re-asserts valid below.
      if (vld_q && Frame_Ready_In) vld_nxt = 1'b0;

      case (state_q)
         IDLE: begin
            en_nxt   = 1'b0;
            busy_nxt = 1'b0;
            if (Start_In && (Channel_Mask_In != 8'd0)) begin
               mask_nxt   = Channel_Mask_In;
               shadow_nxt = 8'd0;
               sel_nxt    = lowest_bit(Channel_Mask_In);
               en_nxt     = 1'b1;
               busy_nxt   = 1'b1;
               cnt_nxt    = 8'd0;
               state_nxt  = DWELL;
            end
         end
         DWELL: begin
            if (cnt_q == CNT_LAST) begin
               cnt_nxt = 8'd0;
               if (remaining != 8'd0) begin
                  shadow_nxt = sample_shadow;
                  sel_nxt    = lowest_bit(remaining);
               end else begin
                  // Last enabled channel: publish the snapshot.
                  frame_nxt = sample_shadow;
                  vld_nxt   = 1'b1;
                  if (vld_q && !Frame_Ready_In) ovr_nxt = 1'b1;
                  if (Continuous_In && (Channel_Mask_In != 8'd0)) begin
                     // Back-to-back scan with no idle gap.
                     mask_nxt   = Channel_Mask_In;
                     shadow_nxt = 8'd0;
                     sel_nxt    = lowest_bit(Channel_Mask_In);
                  end else begin
                     shadow_nxt = sample_shadow;
                     en_nxt     = 1'b0;
                     busy_nxt   = 1'b0;
                     state_nxt  = IDLE;
                  end
               end
            end else begin
               cnt_nxt = cnt_q + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign Select_Out      = sel_q;
   assign Enable_Out      = en_q;
   assign Busy_Out        = busy_q;
   assign Frame_Data_Out  = frame_q;
   assign Frame_Valid_Out = vld_q;
   assign Overrun_Out     = ovr_q;

endmodule

// File: tb/tb_mux_8_1_scanner.sv
// Purpose: directed bench for mux_8_1_scanner with a behavioural 8:1 MUX in the loop.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: Frame_Ready_In driven explicitly per scenario.
module tb_mux_8_1_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] mask;
   logic       cont;
   logic       mux_out;
   logic [2:0] sel;
   logic       en;
   logic [7:0] frame;
   logic       vld;
   logic       rdy;
   logic       busy;
   logic       ovr;

   logic [7:0] mux_inputs;

   int checks = 0;
   int errors = 0;

   mux_8_1_scanner #(.DWELL_CYCLES(4)) dut (
      .Clock_In        (clk),
      .Reset_In        (rst),
      .Start_In        (start),
      .Channel_Mask_In (mask),
      .Continuous_In   (cont),
      .MUX_Data_In     (mux_out),
      .Select_Out      (sel),
      .Enable_Out      (en),
      .Frame_Data_Out  (frame),
      .Frame_Valid_Out (vld),
      .Frame_Ready_In  (rdy),
      .Busy_Out        (busy),
      .Overrun_Out     (ovr)
   );

   // Behavioural 8:1 MUX driven by the scanner.
   assign mux_out = en ? mux_inputs[sel] : 1'b0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; mask = 8'h00; cont = 1'b0; rdy = 1'b0; mux_inputs = 8'h00;
      #12;
      check("reset_outputs", {29'd0, sel}, 32'd0);
      check("reset_flags", {27'd0, en, busy, vld, ovr, 1'b0}, 32'd0);
      check("reset_frame", {24'd0, frame}, 32'd0);
      step();
      rst = 1'b0;

      // Scenario 1: full mask, data A5
      mask = 8'hFF; mux_inputs = 8'hA5; start = 1'b1;
      step();  // edge 0
      start = 1'b0;
      check("t1_start_sel", {29'd0, sel}, 32'd0);
      check("t1_start_en_busy", {30'd0, en, busy}, 32'd3);
      for (int e = 1; e <= 31; e++) begin
         step();
         check("t1_sel_seq", {29'd0, sel}, 32'(e / 4));
      end
      check("t1_no_early_valid", {31'd0, vld}, 32'd0);
      step();  // edge 32
      check("t1_valid", {31'd0, vld}, 32'd1);
      check("t1_frame", {24'd0, frame}, 32'hA5);
      check("t1_en_busy_fall", {30'd0, en, busy}, 32'd0);
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      check("t1_consumed", {31'd0, vld}, 32'd0);

      // Scenario 2: mask 81, only channels 0 and 7
      mask = 8'h81; mux_inputs = 8'hFF; start = 1'b1;
      step();  // edge 0
      start = 1'b0;
      check("t2_sel_e0", {29'd0, sel}, 32'd0);
      for (int e = 1; e <= 7; e++) begin
         step();
         check("t2_sel_seq", {29'd0, sel}, (e < 4) ? 32'd0 : 32'd7);
      end
      step();  // edge 8
      check("t2_valid", {31'd0, vld}, 32'd1);
      check("t2_frame", {24'd0, frame}, 32'h81);
      check("t2_en_fall", {31'd0, en}, 32'd0);
      check("t2_no_overrun", {31'd0, ovr}, 32'd0);
      rdy = 1'b1;
      step();
      rdy = 1'b0;

      // Scenario 3: start with empty mask is ignored
      mask = 8'h00; start = 1'b1;
      step();
      start = 1'b0;
      for (int e = 0; e < 20; e++) begin
         check("t3_idle", {28'd0, en, busy, vld, ovr}, 32'd0);
         step();
      end
      check("t3_sel_hold", {29'd0, sel}, 32'd7);

      // Scenario 4: continuous with no reader, overrun
      cont = 1'b1; rdy = 1'b0; mask = 8'h0F; mux_inputs = 8'hFF; start = 1'b1;
      step();  // edge 0
      start = 1'b0;
      for (int e = 1; e <= 48; e++) begin
         step();
         if (e < 48) check("t4_en_held", {31'd0, en}, 32'd1);
         if (e == 16) begin
            check("t4_frame1", {24'd0, frame}, 32'h0F);
            check("t4_valid1", {31'd0, vld}, 32'd1);
            check("t4_no_ovr_yet", {31'd0, ovr}, 32'd0);
            mux_inputs = 8'h03;
         end
         if (e == 32) begin
            check("t4_frame2", {24'd0, frame}, 32'h03);
            check("t4_overrun", {31'd0, ovr}, 32'd1);
            cont = 1'b0;
         end
      end
      check("t4_end_idle", {30'd0, en, busy}, 32'd0);
      check("t4_overrun_sticky", {31'd0, ovr}, 32'd1);
      rst = 1'b1;
      #1;
      check("t4_reset_clears_ovr", {30'd0, ovr, vld}, 32'd0);
      step();
      rst = 1'b0;

      // Scenario 5: ready exactly on a continuous scan-end edge
      cont = 1'b1; rdy = 1'b0; mask = 8'h0F; mux_inputs = 8'h05; start = 1'b1;
      step();  // edge 0
      start = 1'b0;
      for (int e = 1; e <= 33; e++) begin
         step();
         if (e == 16) begin
            check("t5_frame1", {24'd0, frame}, 32'h05);
            mux_inputs = 8'h0A;
         end
         if (e == 31) rdy = 1'b1;
         if (e == 32) begin
            check("t5_valid_held", {31'd0, vld}, 32'd1);
            check("t5_frame2", {24'd0, frame}, 32'h0A);
            check("t5_no_overrun", {31'd0, ovr}, 32'd0);
            cont = 1'b0;
         end
         if (e == 33) check("t5_consumed", {31'd0, vld}, 32'd0);
      end
      rdy = 1'b0;

      // Scenario 6: async reset in the middle of channel 3's dwell
      for (int e = 34; e <= 45; e++) step();
      check("t6_sel_ch3", {29'd0, sel}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_reset", {16'd0, sel, en, busy, vld, ovr, frame, 1'b0}, 32'd0);
      step();
      rst = 1'b0;
      step();
      check("t6_after_release", {28'd0, en, busy, vld, ovr}, 32'd0);

      mask = 8'h0C; mux_inputs = 8'h04; start = 1'b1;
      step();  // edge 0
      start = 1'b0;
      mask = 8'hFF;
      check("t6_clean_start", {29'd0, sel}, 32'd2);
      for (int e = 1; e <= 7; e++) begin
         if (e == 2) start = 1'b1;
         step();
         start = 1'b0;
         check("t6_sel_seq", {29'd0, sel}, (e < 4) ? 32'd2 : 32'd3);
      end
      step();  // edge 8
      check("t6_frame", {24'd0, frame}, 32'h04);
      check("t6_valid", {31'd0, vld}, 32'd1);
      check("t6_idle", {30'd0, en, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_8_1_scanner.md
Name: mux_8_1_scanner

Overview:
- Sequencer that sits directly upstream of the 8:1 MUX and drives its Select_In and Enable_In.
- Scans the enabled channels in ascending order and holds each select for a settle time.
- Samples the MUX output back in and assembles one 8-bit snapshot per scan.
- Presents the snapshot to downstream logic through a valid/ready handshake.

Parameters:
DWELL_CYCLES, 4, number of clock cycles each select value is held before the MUX output is sampled; legal range 1..255.

Ports:
Clock_In  input  1  system clock, rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Start_In  input  1  single-cycle start request; sampled only in IDLE.
Channel_Mask_In  input  8  bit i = 1 means channel i is included in the scan.
Continuous_In  input  1  1 = restart a new scan immediately when a scan ends.
MUX_Data_In  input  1  MUX_Data_Out of the 8:1 MUX.
Select_Out  output  3  drives MUX Select_In.
Enable_Out  output  1  drives MUX Enable_In.
Frame_Data_Out  output  8  assembled snapshot; bit i = sampled value of channel i.
Frame_Valid_Out  output  1  Frame_Data_Out holds an unconsumed snapshot.
Frame_Ready_In  input  1  downstream accepts the snapshot.
Busy_Out  output  1  scan in progress.
Overrun_Out  output  1  sticky; a snapshot was overwritten before it was accepted.

Behaviour:
- Reset (asynchronous, immediate, valid mid-scan):
  - All outputs go to 0; state = IDLE.
  - Latched mask, shadow register and dwell counter are cleared.
- States: IDLE, DWELL.
- IDLE:
  - Enable_Out = 0, Busy_Out = 0, Select_Out holds its last value.
  - On an edge with Start_In = 1 and Channel_Mask_In != 0: latch the mask, clear the shadow register, set Select_Out to the lowest set bit, set Enable_Out = 1 and Busy_Out = 1, clear the counter, go to DWELL.
  - Start_In with mask = 0 is ignored.
- DWELL:
  - Select_Out is stable for exactly DWELL_CYCLES cycles.
  - On the DWELL_CYCLES-th edge, MUX_Data_In is written into shadow bit [Select_Out].
  - On that same edge Select_Out moves to the next higher set bit of the latched mask, and the counter clears.
  - MUX_Data_In is never sampled at any other edge.
- Scan end: the edge that samples the highest set channel.
  - Frame_Data_Out is loaded with the shadow value including that last bit; bits of unmasked channels are 0.
  - Frame_Valid_Out is set to 1 on the same edge.
- Timing: with N enabled channels and Start sampled at edge 0, channel k (0-based) is sampled at edge (k+1)*DWELL_CYCLES. Frame_Valid_Out rises after edge N*DWELL_CYCLES.
- After scan end:
  - If Continuous_In = 1 and Channel_Mask_In != 0 at that edge: re-latch the mask and start the next scan on the same edge. There are no idle cycles and Enable_Out stays 1.
  - Otherwise: go to IDLE; Enable_Out and Busy_Out fall on that edge.
- Handshake:
  - Frame_Valid_Out stays 1 and Frame_Data_Out stays stable until an edge with Frame_Ready_In = 1.
  - That edge clears Frame_Valid_Out, unless a new scan ends on the same edge. In that case the new data loads, Valid stays 1, and no overrun is flagged.
- Overrun: a scan end while Valid = 1 and Ready = 0 overwrites Frame_Data_Out and sets Overrun_Out. Overrun_Out is cleared only by reset.
- Start_In while Busy is ignored. Channel_Mask_In changes during a scan do not affect that scan.
- MUX_Data_In may be Z/X while Enable_Out = 0; it is never sampled then.

Test Plan:
1. DWELL_CYCLES = 4, mask 0xFF, MUX model data inputs = 0xA5, Start pulse → Select_Out steps 0..7, each held 4 cycles; Frame_Valid_Out rises after edge 32 with Frame_Data_Out = 0xA5; Enable_Out and Busy_Out fall at edge 32.
2. Mask 0x81, data inputs 0xFF → Select_Out goes 0, then 7, with no other values; Frame_Data_Out = 0x81 valid after edge 8.
3. Mask 0x00 with Start pulse → no output changes; state stays IDLE for 20 cycles.
4. Continuous_In = 1, Frame_Ready_In = 0, mask 0x0F, data changed to 0x03 during the second scan → Enable_Out never drops; first snapshot 0x0F is replaced by 0x03 at edge 32; Overrun_Out = 1 and stays 1.
5. Frame_Ready_In = 1 exactly on a scan-end edge in continuous mode → Frame_Valid_Out stays 1, new data loads, Overrun_Out stays 0.
6. Reset_In asserted mid-dwell of channel 3 (between edges) → all outputs 0 immediately without a clock; after release a Start pulse begins a clean scan from the lowest set bit. A Start pulse issued during a scan leaves the select sequence unchanged.
